// File: rtl/time_set_ctl.sv
// ---------------------------------------------------------------------------
// time_set_ctl
//
// Front-panel controller for setting the time on the digital clock.
//
// Two raw pushbuttons (mode, up) are synchronised and debounced. A debounced
// 0->1 transition is a press event. Releases produce no event. The mode button
// steps a RUN -> SET_HR -> SET_MIN -> RUN cycle. The up button issues
// single-cycle advance pulses to the clock core for the field being set.
// Holding the up button auto-repeats: the first repeat comes HOLD_CYCLES after
// the accepted press, and later repeats come every REPEAT_CYCLES.
//
// While a field is being set, its digits blink. The blank phase toggles every
// BLINK_CYCLES. The phase restarts visible on mode entry and on every advance
// pulse, so the digits stay lit while they are being adjusted. After
// TIMEOUT_CYCLES with no press or pulse, the controller drops back to RUN.
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   rst        in   synchronous, active-high reset
//   btn_mode   in   raw mode button (asynchronous, active-high)
//   btn_up     in   raw advance button (asynchronous, active-high)
//   adv_hr     out  1-cycle pulse: advance hours by one
//   adv_min    out  1-cycle pulse: advance minutes by one
//   mode       out  0 RUN, 1 SET_HR, 2 SET_MIN
//   set_active out  high when mode != RUN
//   blank_hr   out  blank hour digits this cycle
//   blank_min  out  blank minute digits this cycle
//
// Every output comes straight from a flop. No combinational path exists from
// btn_* to any output.
// ---------------------------------------------------------------------------
module time_set_ctl #(
    parameter int unsigned DB_CYCLES      = 1_000_000,
    parameter int unsigned HOLD_CYCLES    = 50_000_000,
    parameter int unsigned REPEAT_CYCLES  = 10_000_000,
    parameter int unsigned BLINK_CYCLES   = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       adv_hr,
    output logic       adv_min,
    output logic [1:0] mode,
    output logic       set_active,
    output logic       blank_hr,
    output logic       blank_min
);

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_HR  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN = 2'd2;

    localparam int unsigned REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;

    localparam int DB_W    = (DB_CYCLES    > 1) ? $clog2(DB_CYCLES)    : 1;
    localparam int REP_W   = (REP_MAX      > 1) ? $clog2(REP_MAX)      : 1;
    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int TO_W    = 32;

    // Terminal counts. Each counter starts at 0 on the cycle its interval
    // begins. It fires on the cycle where the registered count equals N-1,
    // which is exactly N cycles later.
    localparam logic [DB_W-1:0]    DB_LAST      = DB_W'(DB_CYCLES - 1);
    localparam logic [REP_W-1:0]   HOLD_LAST    = REP_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]   REPEAT_LAST  = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST   = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [TO_W-1:0]    TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // -----------------------------------------------------------------------
    // Button input path: index 0 = mode, index 1 = up
    // -----------------------------------------------------------------------
    logic [1:0] btn_raw;
    logic [1:0] press_ev;   // registered single-cycle press events
    logic       db_up;      // debounced level of the up button

    assign btn_raw = {btn_up, btn_mode};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            db_reg;
            logic            press_reg;
            logic [DB_W-1:0] db_cnt_reg;

            // The debounced level flips after DB_CYCLES consecutive
            // synchronised samples that disagree with it. Any agreeing sample
            // restarts the count. A press is flagged on the same edge as a
            // 0->1 flip, so the control logic sees it one cycle later.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    db_reg     <= 1'b0;
                    press_reg  <= 1'b0;
                    db_cnt_reg <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg != db_reg) begin
                        if (db_cnt_reg == DB_LAST) begin
                            db_reg     <= sync2_reg;
                            db_cnt_reg <= '0;
                            press_reg  <= sync2_reg;
                        end else begin
                            db_cnt_reg <= db_cnt_reg + DB_W'(1);
                        end
                    end else begin
                        db_cnt_reg <= '0;
                    end
                end
            end

            assign press_ev[gi] = press_reg;

            // Only the up button's level matters beyond its press event
            // (it gates auto-repeat).
            if (gi == 1) begin : g_up_level
                assign db_up = db_reg;
            end
        end
    endgenerate

    logic mode_press;
    logic up_press;

    assign mode_press = press_ev[0];
    assign up_press   = press_ev[1];

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    logic [1:0]         mode_reg,       mode_next;
    logic [TO_W-1:0]    to_cnt_reg,     to_cnt_next;
    logic               rep_active_reg, rep_active_next;
    logic               rep_first_reg,  rep_first_next;
    logic [REP_W-1:0]   rep_cnt_reg,    rep_cnt_next;
    logic [BLINK_W-1:0] blink_cnt_reg,  blink_cnt_next;
    logic               phase_reg,      phase_next;
    logic               adv_hr_reg,     adv_hr_next;
    logic               adv_min_reg,    adv_min_next;
    logic               set_active_reg, set_active_next;
    logic               blank_hr_reg,   blank_hr_next;
    logic               blank_min_reg,  blank_min_next;

    // Event priority within one cycle:
    //   mode press > accepted up press > repeat pulse > inactivity timeout.
    // A mode press swallows a coincident up press. It also swallows a
    // coincident repeat pulse, because the field being set is about to change.
    logic             in_set;
    logic             up_accept;
    logic             rep_pulse;
    logic             adv_any;
    logic             timeout_hit;
    logic [REP_W-1:0] rep_limit;

    assign in_set      = (mode_reg != MODE_RUN);
    assign up_accept   = up_press & in_set & ~mode_press;
    assign rep_limit   = rep_first_reg ? HOLD_LAST : REPEAT_LAST;
    assign rep_pulse   = rep_active_reg & db_up & in_set & ~mode_press
                         & (rep_cnt_reg == rep_limit);
    assign adv_any     = up_accept | rep_pulse;
    assign timeout_hit = in_set & ~mode_press & ~adv_any
                         & (to_cnt_reg == TIMEOUT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg       <= MODE_RUN;
            to_cnt_reg     <= '0;
            rep_active_reg <= 1'b0;
            rep_first_reg  <= 1'b0;
            rep_cnt_reg    <= '0;
            blink_cnt_reg  <= '0;
            phase_reg      <= 1'b0;
            adv_hr_reg     <= 1'b0;
            adv_min_reg    <= 1'b0;
            set_active_reg <= 1'b0;
            blank_hr_reg   <= 1'b0;
            blank_min_reg  <= 1'b0;
        end else begin
            mode_reg       <= mode_next;
            to_cnt_reg     <= to_cnt_next;
            rep_active_reg <= rep_active_next;
            rep_first_reg  <= rep_first_next;
            rep_cnt_reg    <= rep_cnt_next;
            blink_cnt_reg  <= blink_cnt_next;
            phase_reg      <= phase_next;
            adv_hr_reg     <= adv_hr_next;
            adv_min_reg    <= adv_min_next;
            set_active_reg <= set_active_next;
            blank_hr_reg   <= blank_hr_next;
            blank_min_reg  <= blank_min_next;
        end
    end

    // Next-state logic: mode FSM, repeat, inactivity and blink timers
    always_comb begin
        mode_next       = mode_reg;
        to_cnt_next     = to_cnt_reg;
        rep_active_next = rep_active_reg;
        rep_first_next  = rep_first_reg;
        rep_cnt_next    = rep_cnt_reg;
        blink_cnt_next  = blink_cnt_reg;
        phase_next      = phase_reg;

        if (mode_press) begin
            case (mode_reg)
                MODE_RUN:    mode_next = MODE_SET_HR;
                MODE_SET_HR: mode_next = MODE_SET_MIN;
                default:     mode_next = MODE_RUN;
            endcase
        end else if (timeout_hit) begin
            mode_next = MODE_RUN;
        end

        // Auto-repeat. Any mode change cancels it. A fresh release and
        // re-press is then needed before pulses resume.
        if (mode_press || (mode_next == MODE_RUN)) begin
            rep_active_next = 1'b0;
            rep_first_next  = 1'b0;
            rep_cnt_next    = '0;
        end else if (up_accept) begin
            rep_active_next = 1'b1;
            rep_first_next  = 1'b1;
            rep_cnt_next    = '0;
        end else if (rep_active_reg) begin
            if (!db_up) begin
                rep_active_next = 1'b0;
                rep_first_next  = 1'b0;
                rep_cnt_next    = '0;
            end else if (rep_pulse) begin
                rep_first_next = 1'b0;
                rep_cnt_next   = '0;
            end else begin
                rep_cnt_next = rep_cnt_reg + REP_W'(1);
            end
        end

        // Inactivity counter. It is held at 0 in RUN and restarts on any
        // activity.
        if ((mode_next == MODE_RUN) || mode_press || adv_any) begin
            to_cnt_next = '0;
        end else begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
        end

        // Blink phase. Restart visible on mode entry and on each advance.
        if ((mode_next == MODE_RUN) || mode_press || adv_any) begin
            blink_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
        end else begin
            blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        adv_hr_next     = adv_any & (mode_reg == MODE_SET_HR);
        adv_min_next    = adv_any & (mode_reg == MODE_SET_MIN);
        set_active_next = (mode_next != MODE_RUN);
        blank_hr_next   = (mode_next == MODE_SET_HR)  & phase_next;
        blank_min_next  = (mode_next == MODE_SET_MIN) & phase_next;
    end

    assign mode       = mode_reg;
    assign adv_hr     = adv_hr_reg;
    assign adv_min    = adv_min_reg;
    assign set_active = set_active_reg;
    assign blank_hr   = blank_hr_reg;
    assign blank_min  = blank_min_reg;

endmodule

// File: tb/tb_time_set_ctl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctl
//
// The driver applies directed and random button sequences. For every clock
// edge it steps a behavioural model of the front panel. The model pushes the
// expected status for that edge into a queue. Every expected advance pulse is
// pushed into a second queue, stamped with its cycle. An independent monitor
// samples the DUT after every edge. It pops the status queue and compares.
// Whenever the DUT shows an advance pulse, it pops the pulse queue and checks
// both the cycle and the field.
//
// The model works on time stamps. The debounced level flips when the last
// DB synchronised samples all disagree with it. Auto-repeat, blink phase and
// timeout are computed from the cycle of the last relevant event.
// ---------------------------------------------------------------------------
module tb_time_set_ctl;

    localparam int TB_DB      = 4;
    localparam int TB_HOLD    = 20;
    localparam int TB_REPEAT  = 5;
    localparam int TB_BLINK   = 8;
    localparam int TB_TIMEOUT = 100;

    logic       clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_up;
    logic       adv_hr;
    logic       adv_min;
    logic [1:0] mode;
    logic       set_active;
    logic       blank_hr;
    logic       blank_min;

    time_set_ctl #(
        .DB_CYCLES      (TB_DB),
        .HOLD_CYCLES    (TB_HOLD),
        .REPEAT_CYCLES  (TB_REPEAT),
        .BLINK_CYCLES   (TB_BLINK),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .adv_hr     (adv_hr),
        .adv_min    (adv_min),
        .mode       (mode),
        .set_active (set_active),
        .blank_hr   (blank_hr),
        .blank_min  (blank_min)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [1:0] mode;
        logic       set_active;
        logic       blank_hr;
        logic       blank_min;
    } status_t;

    typedef struct {
        int cyc;
        bit is_hr;
    } pulse_t;

    status_t exp_q[$];
    pulse_t  pulse_q[$];

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model state ----------------
    int m_edge      = 0;
    int m_mode      = 0;
    bit m_armed     = 0;
    int m_next_rep  = 0;
    int m_last_act  = 0;
    int m_blink_ref = 0;
    bit m_pend [2];            // press seen by the debouncer, acted on next edge
    bit m_db   [2];            // debounced level
    bit m_s1   [2];            // first synchroniser stage
    bit m_s2   [2];            // second synchroniser stage
    bit m_hist [2][TB_DB];     // recent s2 samples, index 0 newest
    int m_hcnt [2];

    task automatic model_step(input bit r, input bit bm, input bit bu);
        status_t st;
        pulse_t  p;
        int      adv_kind;
        bit      dbu_prev;
        bit      raw [2];
        bit      flip;
        bit      new_s2;
        int      ph;
        m_edge++;
        raw[0] = bm;
        raw[1] = bu;
        if (r) begin
            m_mode  = 0;
            m_armed = 0;
            for (int b = 0; b < 2; b++) begin
                m_pend[b] = 0;
                m_db[b]   = 0;
                m_s1[b]   = 0;
                m_s2[b]   = 0;
                for (int k = TB_DB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
                m_hist[b][0] = 0;
                if (m_hcnt[b] < TB_DB) m_hcnt[b]++;
            end
            st = '0;
            exp_q.push_back(st);
            return;
        end
        dbu_prev = m_db[1];
        adv_kind = 0;
        if (m_pend[0]) begin
            m_mode  = (m_mode + 1) % 3;
            m_armed = 0;
            if (m_mode != 0) begin
                m_last_act  = m_edge;
                m_blink_ref = m_edge;
            end
        end else if (m_pend[1] && m_mode != 0) begin
            adv_kind    = m_mode;
            m_armed     = 1;
            m_next_rep  = m_edge + TB_HOLD;
            m_last_act  = m_edge;
            m_blink_ref = m_edge;
        end else begin
            if (m_armed && !dbu_prev) m_armed = 0;
            if (m_armed && m_edge == m_next_rep) begin
                adv_kind    = m_mode;
                m_next_rep  = m_edge + TB_REPEAT;
                m_last_act  = m_edge;
                m_blink_ref = m_edge;
            end else if (m_mode != 0 && (m_edge - m_last_act) == TB_TIMEOUT) begin
                m_mode  = 0;
                m_armed = 0;
            end
        end
        if (adv_kind != 0) begin
            p.cyc   = m_edge;
            p.is_hr = (adv_kind == 1);
            pulse_q.push_back(p);
        end
        ph = ((m_edge - m_blink_ref) / TB_BLINK) % 2;
        st.mode       = 2'(m_mode);
        st.set_active = (m_mode != 0);
        st.blank_hr   = (m_mode == 1) && (ph == 1);
        st.blank_min  = (m_mode == 2) && (ph == 1);
        exp_q.push_back(st);
        // debouncer for this edge, then the synchroniser shift
        for (int b = 0; b < 2; b++) begin
            flip = (m_hcnt[b] == TB_DB);
            for (int k = 0; k < TB_DB; k++) if (m_hist[b][k] == m_db[b]) flip = 0;
            if (flip) begin
                m_db[b]   = ~m_db[b];
                m_pend[b] = m_db[b];
            end else begin
                m_pend[b] = 0;
            end
            new_s2  = m_s1[b];
            m_s1[b] = raw[b];
            m_s2[b] = new_s2;
            for (int k = TB_DB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
            m_hist[b][0] = new_s2;
            if (m_hcnt[b] < TB_DB) m_hcnt[b]++;
        end
    endtask

    // ---------------- monitor ----------------
    int mon_cyc = 0;

    initial begin : monitor
        status_t st;
        status_t got;
        pulse_t  p;
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            if (exp_q.size() > 0) begin
                st  = exp_q.pop_front();
                got = {mode, set_active, blank_hr, blank_min};
                checks++;
                if (got !== st) begin
                    errors++;
                    $display("FAIL status cyc=%0d got mode=%0d set=%b bh=%b bm=%b want mode=%0d set=%b bh=%b bm=%b",
                             mon_cyc, got.mode, got.set_active, got.blank_hr, got.blank_min,
                             st.mode, st.set_active, st.blank_hr, st.blank_min);
                end
            end
            while (pulse_q.size() > 0 && pulse_q[0].cyc < mon_cyc) begin
                p = pulse_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_pulse cyc=%0d got none want %s", p.cyc, p.is_hr ? "adv_hr" : "adv_min");
            end
            if (adv_hr === 1'b1 || adv_min === 1'b1) begin
                checks++;
                if (pulse_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d got hr=%b min=%b want none", mon_cyc, adv_hr, adv_min);
                end else begin
                    p = pulse_q.pop_front();
                    if (p.cyc != mon_cyc || adv_hr !== p.is_hr || adv_min !== !p.is_hr) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d got hr=%b min=%b want cyc=%0d hr=%b min=%b",
                                 mon_cyc, adv_hr, adv_min, p.cyc, p.is_hr, !p.is_hr);
                    end else begin
                        $display("pulse cyc=%0d %s ok", mon_cyc, p.is_hr ? "adv_hr" : "adv_min");
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cycle(input bit r, input bit bm, input bit bu);
        rst      = r;
        btn_mode = bm;
        btn_up   = bu;
        model_step(r, bm, bu);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0);
    endtask

    task automatic press_mode();
        repeat (10) cycle(0, 1, 0);
        idle(10);
    endtask

    task automatic press_up(input int hold);
        repeat (hold) cycle(0, 0, 1);
        idle(10);
    endtask

    initial begin : driver
        int len;
        bit bm;
        bit bu;
        for (int b = 0; b < 2; b++) begin
            m_pend[b] = 0;
            m_db[b]   = 0;
            m_s1[b]   = 0;
            m_s2[b]   = 0;
            m_hcnt[b] = 0;
            for (int k = 0; k < TB_DB; k++) m_hist[b][k] = 0;
        end

        // reset with both buttons held, then keep holding: coincident
        // presses after reset, mode wins
        repeat (3) cycle(1, 1, 1);
        repeat (12) cycle(0, 1, 1);
        idle(10);
        repeat (2) cycle(1, 0, 0);
        idle(5);

        // bouncing up button in RUN never debounces
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1); cycle(0, 0, 1);
            cycle(0, 0, 0); cycle(0, 0, 0);
        end
        press_mode();                 // SET_HR
        cycle(0, 1, 0); idle(10);     // glitch on mode
        press_up(10);                 // adv_hr
        press_mode();                 // SET_MIN
        press_up(10);                 // adv_min
        press_mode();                 // RUN
        press_up(10);                 // ignored in RUN

        // auto-repeat in SET_MIN
        press_mode(); press_mode();
        press_up(60);

        // collision in SET_HR
        press_mode(); press_mode();   // RUN, SET_HR
        repeat (10) cycle(0, 1, 1);
        idle(10);
        press_mode();                 // RUN

        // blink and timeout in SET_HR
        press_mode();
        idle(120);

        // reset in the middle of an auto-repeat
        press_mode();
        repeat (40) cycle(0, 0, 1);
        cycle(1, 0, 1);
        repeat (15) cycle(0, 0, 1);
        idle(10);

        // random segments
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 24) == 0) begin
                repeat ($urandom_range(1, 2)) cycle(1, 0, 0);
            end else begin
                bm  = ($urandom_range(0, 3) == 0);
                bu  = ($urandom_range(0, 2) == 0);
                len = $urandom_range(1, 45);
                repeat (len) cycle(0, bm, bu);
            end
        end
        idle(30);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0 || pulse_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got status=%0d pulses=%0d want 0 0", exp_q.size(), pulse_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
